mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing the single physical memory port between the instruction-fetch side (I) and the MEM-stage data side (D) of the rv32i pipeline. It accepts level-held requests, grants one at a time through a small FSM, drives registered commands to memory, and routes `mem_resp`/`mem_rdata` back to the granted requester. Requesters stall on their own until they see their response pulse.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; must be a multiple of 8
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `i_read`  in  1  I-side read request, held until `i_resp`
- `i_addr`  in  ADDR_W  I-side address
- `i_resp`  out  1  I-side completion pulse, one cycle
- `i_rdata`  out  DATA_W  I-side read data, valid with `i_resp`
- `d_read`  in  1  D-side read request, held until `d_resp`
- `d_write`  in  1  D-side write request, held until `d_resp`
- `d_addr`  in  ADDR_W  D-side address
- `d_wdata`  in  DATA_W  D-side write data
- `d_wmask`  in  DATA_W/8  D-side byte enables
- `d_resp`  out  1  D-side completion pulse, one cycle
- `d_rdata`  out  DATA_W  D-side read data, valid with `d_resp`
- `mem_read`  out  1  memory read command, registered
- `mem_write`  out  1  memory write command, registered
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_wmask`  out  DATA_W/8  registered byte mask (all ones on reads)
- `mem_resp`  in  1  memory completion, one cycle
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_resp`
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- IDLE: sample requests at clock edge. D pending (`d_read|d_write`) and no I → D_BUSY. I only → I_BUSY. Both → per arbitration policy (see Configuration). None → stay.
- On grant edge: latch addr/wdata/wmask/command into `mem_*` registers. `d_write` and `d_read` both high: treated as write; simulation assertion fires.
- I_BUSY / D_BUSY: hold `mem_*` stable until `mem_resp`. On `mem_resp`: combinationally pulse granted `*_resp`, route `mem_rdata` to its `*_rdata`; clear `mem_read/mem_write` and return to IDLE at that edge.
- Non-granted `*_resp` always 0. `*_rdata` = `mem_rdata` ungated (qualified only by `*_resp`).
- `mem_resp` in IDLE: ignored, no response pulses.
- Requester dropping its request before response (protocol violation): transaction still completes; response still pulsed; assertion fires.
- Request changes (addr/data) while granted: ignored; latched values used.

## Timing
- Reset (async): state IDLE, `mem_read=mem_write=0`, `mem_addr=mem_wdata=0`, `mem_wmask=0`, `busy=0`, `i_resp=d_resp=0`, round-robin pointer = D-last (so I wins the first tie).
- Grant latency: request high in cycle 0 → `mem_read`/`mem_write` high in cycle 1.
- Response: `mem_resp` in cycle N → `*_resp` in cycle N (same cycle); IDLE in N+1; earliest next memory command cycle N+2.
- Requester must drop request in cycle N+1 (sees resp at edge ending N); a new request held in N+1 is eligible.
- Reset mid-transaction: commands drop immediately; late `mem_resp` after reset is ignored (IDLE rule).

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: one-bit last-grant flop; on simultaneous I and D requests in IDLE, grant the side not granted last; flop updates on every grant.
- Undefined: fixed priority, D always wins ties (older instruction); I may wait arbitrarily long behind back-to-back D traffic. No last-grant flop.

## Test plan
- I read 0x0000_0040 alone, memory responds after 3 cycles with 0xDEAD_BEEF → `mem_read` cycle 1, `i_resp` + `i_rdata=0xDEAD_BEEF` cycle 4, `d_resp` never.
- D write addr 0x100, wdata 0x1234_5678, wmask 0b0011 → `mem_write=1`, `mem_wmask=0b0011`, `mem_wdata` stable until `mem_resp`; `d_resp` single pulse.
- I and D both request in same cycle, fixed priority → D served first, I granted cycle N+1 IDLE, I command at N+2.
- With `MEM_ARB_ROUND_ROBIN_EN`, both held continuously for 4 transactions → grants I, D, I, D.
- Assert `rst` while D_BUSY, then pulse `mem_resp` → outputs zero immediately, no `d_resp`, state IDLE.
- `mem_resp` pulsed in IDLE with no requests → no `i_resp`/`d_resp`, `busy` stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the I-fetch and D-side requesters.
// Grants one level-held request at a time, registers the memory command, and routes
// mem_resp/mem_rdata back to the granted side.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternate grants on ties; default D wins).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_resp,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_resp,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

    state_e state_q, state_d;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;
    logic   tie_to_i;

    assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_q;

    // Remember which side won the most recent grant; reset as "D last" so I wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b1;
        end else if (grant_i) begin
            last_d_q <= 1'b0;
        end else if (grant_d) begin
            last_d_q <= 1'b1;
        end
    end

    assign tie_to_i = last_d_q;
`else
    // Fixed priority: the data side holds the older instruction, so it wins ties.
    assign tie_to_i = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration and next-state decode.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_read && d_req) begin
                    grant_i = tie_to_i;
                    grant_d = !tie_to_i;
                end else begin
                    grant_i = i_read;
                    grant_d = d_req;
                end
                if (grant_i) begin
                    state_d = StIBusy;
                end else if (grant_d) begin
                    state_d = StDBusy;
                end
            end
            StIBusy, StDBusy: begin
                if (mem_resp) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Latch the granted command; hold it until mem_resp, then drop the strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (grant_i) begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wmask <= '1;
        end else if (grant_d) begin
            // Write takes precedence if both D strobes are (illegally) high.
            mem_read  <= !d_write;
            mem_write <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wmask <= d_write ? d_wmask : '1;
        end else if (state_q != StIdle && mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    // Responses are combinational from mem_resp; read data is passed through ungated.
    always_comb begin
        i_resp  = (state_q == StIBusy) && mem_resp;
        d_resp  = (state_q == StDBusy) && mem_resp;
        i_rdata = mem_rdata;
        d_rdata = mem_rdata;
        busy    = (state_q != StIdle);
    end

`ifndef SYNTHESIS
    // Protocol checks: conflicting D strobes, and a granted requester dropping early.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (grant_d) begin
                assert (!(d_read && d_write))
                    else $error("mem_port_arbiter: d_read and d_write both high at grant");
            end
            if (state_q == StIBusy) begin
                assert (i_read) else $error("mem_port_arbiter: i_read dropped before i_resp");
            end
            if (state_q == StDBusy) begin
                assert (d_req) else $error("mem_port_arbiter: D request dropped before d_resp");
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction scoreboard for mem_port_arbiter.
// Build with MEM_ARB_ROUND_ROBIN_EN to check the round-robin tie policy.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    localparam int DropKeep = 0;
    localparam int DropOwn  = 1;
    localparam int DropAll  = 2;

    typedef struct packed {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        logic [DW-1:0] rdata;
    } txn_t;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic          i_resp;
    logic [DW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [MW-1:0] d_wmask;
    logic          d_resp;
    logic [DW-1:0] d_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_resp;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int   vectors;
    int   miscompares;
    txn_t sb[$];
    logic rr_last_d;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_resp    (i_resp),
        .i_rdata   (i_rdata),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_resp    (d_resp),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record an expected grant; also advances the bench's model of the last-granted side.
    task automatic push(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [MW-1:0] wmask,
                        input logic [DW-1:0] rdata);
        txn_t t;
        t.is_d  = is_d;
        t.wr    = wr;
        t.addr  = addr;
        t.wdata = wdata;
        t.wmask = wmask;
        t.rdata = rdata;
        sb.push_back(t);
        rr_last_d = is_d;
    endtask

    // Which side should win a simultaneous I/D request.
    function automatic logic tie_is_d();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !rr_last_d;
`else
        return 1'b1;
`endif
    endfunction

    // Wait for the next command, check it against the scoreboard, respond after lat cycles.
    task automatic serve(input int lat, input int drop);
        txn_t          e;
        int            n;
        logic [AW-1:0] sa_i;
        logic [AW-1:0] sa_d;
        logic [DW-1:0] sw;
        logic [MW-1:0] sm;
        n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            tick();
            n++;
        end
        chk("grant_latency", 64'(n), 64'd1);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("cmd_read", 64'(mem_read), 64'(!e.wr));
        chk("cmd_write", 64'(mem_write), 64'(e.wr));
        chk("cmd_addr", 64'(mem_addr), 64'(e.addr));
        chk("cmd_wmask", 64'(mem_wmask), e.wr ? 64'(e.wmask) : 64'hF);
        if (e.wr) chk("cmd_wdata", 64'(mem_wdata), 64'(e.wdata));
        // Scramble requester inputs while granted; the latched command must not move.
        sa_i = i_addr; sa_d = d_addr; sw = d_wdata; sm = d_wmask;
        i_addr = ~i_addr; d_addr = ~d_addr; d_wdata = ~d_wdata; d_wmask = ~d_wmask;
        repeat (lat) begin
            tick();
            chk("hold_addr", 64'(mem_addr), 64'(e.addr));
            if (e.wr) chk("hold_wdata", 64'(mem_wdata), 64'(e.wdata));
            chk("hold_cmd", 64'({mem_read, mem_write}), e.wr ? 64'd1 : 64'd2);
            chk("hold_busy", 64'(busy), 64'd1);
            chk("no_early_resp", 64'({i_resp, d_resp}), 64'd0);
        end
        i_addr = sa_i; d_addr = sa_d; d_wdata = sw; d_wmask = sm;
        mem_resp  = 1'b1;
        mem_rdata = e.rdata;
        #1;
        chk("i_resp", 64'(i_resp), 64'(!e.is_d));
        chk("d_resp", 64'(d_resp), 64'(e.is_d));
        if (e.is_d) chk("d_rdata", 64'(d_rdata), 64'(e.rdata));
        else        chk("i_rdata", 64'(i_rdata), 64'(e.rdata));
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 32'h5A5A_0000 ^ $urandom;
        chk("idle_after_resp", 64'(busy), 64'd0);
        chk("cmd_cleared", 64'({mem_read, mem_write}), 64'd0);
        chk("resp_single_pulse", 64'({i_resp, d_resp}), 64'd0);
        if (drop == DropAll || (drop == DropOwn && e.is_d)) begin
            d_read = 1'b0; d_write = 1'b0;
        end
        if (drop == DropAll || (drop == DropOwn && !e.is_d)) begin
            i_read = 1'b0;
        end
    endtask

    initial begin
        logic first_d;
        int   n;
        vectors     = 0;
        miscompares = 0;
        rr_last_d   = 1'b1;
        rst = 1'b1;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_cmd", 64'({mem_read, mem_write}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_wmask", 64'(mem_wmask), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp", 64'({i_resp, d_resp}), 64'd0);
        tick();

        // I read alone, memory answers three cycles after the command.
        i_read = 1'b1; i_addr = 32'h0000_0040;
        push(1'b0, 1'b0, 32'h0000_0040, '0, '1, 32'hDEAD_BEEF);
        serve(3, DropOwn);
        tick();

        // D partial write.
        d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678; d_wmask = 4'b0011;
        push(1'b1, 1'b1, 32'h100, 32'h1234_5678, 4'b0011, 32'h0BAD_0BAD);
        serve(2, DropOwn);
        tick();

        // D read, immediate response.
        d_read = 1'b1; d_addr = 32'h200;
        push(1'b1, 1'b0, 32'h200, '0, '1, 32'hCAFE_F00D);
        serve(1, DropOwn);
        tick();

        // Simultaneous I and D: winner by policy, loser granted from the following IDLE.
        i_read = 1'b1; i_addr = 32'h300;
        d_write = 1'b1; d_addr = 32'h400; d_wdata = 32'hA5A5_5A5A; d_wmask = 4'b1100;
        first_d = tie_is_d();
        if (first_d) begin
            push(1'b1, 1'b1, 32'h400, 32'hA5A5_5A5A, 4'b1100, 32'h1111_1111);
            push(1'b0, 1'b0, 32'h300, '0, '1, 32'h2222_2222);
        end else begin
            push(1'b0, 1'b0, 32'h300, '0, '1, 32'h2222_2222);
            push(1'b1, 1'b1, 32'h400, 32'hA5A5_5A5A, 4'b1100, 32'h1111_1111);
        end
        serve(1, DropOwn);
        serve(2, DropOwn);
        tick();

        // Both sides held for four back-to-back transactions.
        i_read = 1'b1; i_addr = 32'h600;
        d_read = 1'b1; d_addr = 32'h500;
        for (int k = 0; k < 4; k++) begin
            if (tie_is_d()) push(1'b1, 1'b0, 32'h500, '0, '1, 32'hD000_0000 + 32'(k));
            else            push(1'b0, 1'b0, 32'h600, '0, '1, 32'h1000_0000 + 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            serve(1 + k, (k == 3) ? DropAll : DropKeep);
        end
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Stray mem_resp in IDLE is ignored.
        mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle_resp_ignored", 64'({i_resp, d_resp}), 64'd0);
        tick();
        mem_resp = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_no_cmd", 64'({mem_read, mem_write}), 64'd0);

        // Reset in the middle of a D write, then a late mem_resp.
        d_write = 1'b1; d_addr = 32'h700; d_wdata = 32'h7777_7777; d_wmask = 4'b1111;
        n = 0;
        while (!mem_write && n < 20) begin
            tick();
            n++;
        end
        chk("rst_test_grant", 64'(n), 64'd1);
        tick();
        chk("rst_test_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        d_write = 1'b0;
        #1;
        chk("async_rst_cmd", 64'({mem_read, mem_write}), 64'd0);
        chk("async_rst_addr", 64'(mem_addr), 64'd0);
        chk("async_rst_wdata", 64'(mem_wdata), 64'd0);
        chk("async_rst_wmask", 64'(mem_wmask), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        mem_resp = 1'b1;
        #1;
        chk("rst_late_resp", 64'({i_resp, d_resp}), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_late_resp", 64'({i_resp, d_resp}), 64'd0);
        tick();
        mem_resp = 1'b0;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_cmd", 64'({mem_read, mem_write}), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
